// File: rtl/stream_demux_1ton_if.sv
// Valid/ready bundle for the 1-to-N stream demultiplexer: one input stream
// and NUM_OUT output channels packed side by side.
interface stream_demux_1ton_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_OUT   = 4
);
    localparam int SEL_W = $clog2(NUM_OUT);

    logic [WORD_SIZE-1:0]         in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic [SEL_W-1:0]             in_sel;
    logic [NUM_OUT*WORD_SIZE-1:0] out_data;
    logic [NUM_OUT-1:0]           out_valid;
    logic [NUM_OUT-1:0]           out_ready;
    logic [NUM_OUT-1:0]           out_last;

    modport slave (
        input  in_data, in_valid, in_last, in_sel, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, in_sel, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// Packet-routed 1-to-NUM_OUT stream demux. The destination is latched on a
// packet's first beat; each channel drains through its own 2-entry skid FIFO.
module stream_demux_1ton #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_OUT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_demux_1ton_if.slave    io,
    output logic                  busy,
    output logic                  err_sel
);
    localparam int SEL_W = $clog2(NUM_OUT);
    localparam logic [SEL_W:0] NUM_OUT_C = (SEL_W+1)'(NUM_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic [SEL_W-1:0]   push_dest;
    logic               err_q, err_d;
    logic               sel_ok;
    logic               in_ready_w;
    logic               push_en;
    logic [NUM_OUT-1:0] full_w;

    assign sel_ok = ({1'b0, io.in_sel} < NUM_OUT_C);

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        err_d      = err_q;
        in_ready_w = 1'b0;
        push_en    = 1'b0;
        push_dest  = dest_q;
        case (state_q)
            S_IDLE: begin
                push_dest  = io.in_sel;
                // A bad destination is always accepted so the packet can be flushed.
                in_ready_w = !sel_ok || !full_w[io.in_sel];
                if (io.in_valid && in_ready_w) begin
                    push_en = sel_ok;
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end
                    if (!io.in_last) begin
                        state_d = sel_ok ? S_ROUTE : S_DROP;
                        dest_d  = io.in_sel;
                    end
                end
            end
            S_ROUTE: begin
                in_ready_w = !full_w[dest_q];
                if (io.in_valid && in_ready_w) begin
                    push_en = 1'b1;
                    if (io.in_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                in_ready_w = 1'b1;
                if (io.in_valid && io.in_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    assign io.in_ready = in_ready_w;
    assign busy        = (state_q == S_ROUTE);
    assign err_sel     = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
            logic [1:0]           cnt_q, cnt_d;
            logic [WORD_SIZE-1:0] d0_q, d0_d, d1_q, d1_d;
            logic                 l0_q, l0_d, l1_q, l1_d;
            logic                 push, pop;

            assign push        = push_en && (push_dest == SEL_W'(gi));
            assign pop         = (cnt_q != 2'd0) && io.out_ready[gi];
            assign full_w[gi]  = (cnt_q == 2'd2);

            // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
            always_comb begin
                cnt_d = cnt_q;
                d0_d  = d0_q;
                d1_d  = d1_q;
                l0_d  = l0_q;
                l1_d  = l1_q;
                if (pop) begin
                    d0_d  = d1_q;
                    l0_d  = l1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                if (push) begin
                    if (cnt_d == 2'd0) begin
                        d0_d = io.in_data;
                        l0_d = io.in_last;
                    end else begin
                        d1_d = io.in_data;
                        l1_d = io.in_last;
                    end
                    cnt_d = cnt_d + 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= 2'd0;
                    d0_q  <= '0;
                    d1_q  <= '0;
                    l0_q  <= 1'b0;
                    l1_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    d0_q  <= d0_d;
                    d1_q  <= d1_d;
                    l0_q  <= l0_d;
                    l1_q  <= l1_d;
                end
            end

            assign io.out_valid[gi]                         = (cnt_q != 2'd0);
            assign io.out_data[gi*WORD_SIZE +: WORD_SIZE]   = (cnt_q != 2'd0) ? d0_q : '0;
            assign io.out_last[gi]                          = (cnt_q != 2'd0) && l0_q;
        end
    endgenerate
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: a 4-channel instance for routing and
// flow control, a 3-channel instance for out-of-range destinations.
module tb_stream_demux_1ton;
    logic clk = 1'b0;
    logic reset;
    logic busy4, err4, busy3, err3;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] obs4 [$];
    logic [31:0] obs3 [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    stream_demux_1ton_if #(.WORD_SIZE(16), .NUM_OUT(4)) if4 ();
    stream_demux_1ton_if #(.WORD_SIZE(16), .NUM_OUT(3)) if3 ();

    stream_demux_1ton #(.WORD_SIZE(16), .NUM_OUT(4)) u_dut4 (
        .clk(clk), .reset(reset), .io(if4), .busy(busy4), .err_sel(err4)
    );
    stream_demux_1ton #(.WORD_SIZE(16), .NUM_OUT(3)) u_dut3 (
        .clk(clk), .reset(reset), .io(if3), .busy(busy3), .err_sel(err3)
    );

    // Beat record: channel in [23:20], last in [16], data in [15:0].
    function automatic logic [31:0] mk(input int ch, input logic last, input logic [15:0] d);
        return {8'h00, ch[3:0], 3'b000, last, d};
    endfunction

    // Handshakes complete at the next rising edge; record them mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (if4.out_valid[i] && if4.out_ready[i])
                obs4.push_back(mk(i, if4.out_last[i], if4.out_data[i*16 +: 16]));
        for (int i = 0; i < 3; i++)
            if (if3.out_valid[i] && if3.out_ready[i])
                obs3.push_back(mk(i, if3.out_last[i], if3.out_data[i*16 +: 16]));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_obs(input string tag, input bit on3);
        logic [31:0] got [$];
        if (on3) got = obs3; else got = obs4;
        check($sformatf("%s_count", tag), 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s_beat%0d", tag, k),
                  (k < got.size()) ? got[k] : 32'hFFFF_FFFF, exp_q[k]);
        exp_q.delete();
        obs4.delete();
        obs3.delete();
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input bit on3, input logic [15:0] d, input logic [1:0] s, input logic l);
        int   n = 0;
        logic rdy;
        if (on3) begin
            if3.in_data = d; if3.in_sel = s; if3.in_last = l; if3.in_valid = 1'b1;
        end else begin
            if4.in_data = d; if4.in_sel = s; if4.in_last = l; if4.in_valid = 1'b1;
        end
        @(negedge clk);
        rdy = on3 ? if3.in_ready : if4.in_ready;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
            rdy = on3 ? if3.in_ready : if4.in_ready;
        end
        check($sformatf("send_ready_%h", d), 32'(rdy), 32'd1);
        @(posedge clk); #1;
        if (on3) if3.in_valid = 1'b0; else if4.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if4.in_valid = 1'b1; if4.in_data = 16'h00AA; if4.in_sel = 2'd0; if4.in_last = 1'b0;
        if4.out_ready = 4'hF;
        if3.in_valid = 1'b1; if3.in_data = 16'h00BB; if3.in_sel = 2'd0; if3.in_last = 1'b0;
        if3.out_ready = 3'h7;
        idle(2);

        // Reset held with in_valid high: outputs idle, IDLE ready rule applies.
        check("rst_out_valid", 32'(if4.out_valid), 32'd0);
        check("rst_out_data",  32'(if4.out_data[31:0]), 32'd0);
        check("rst_out_last",  32'(if4.out_last), 32'd0);
        check("rst_busy",      32'(busy4), 32'd0);
        check("rst_err",       32'(err4), 32'd0);
        check("rst_in_ready",  32'(if4.in_ready), 32'd1);
        check("rst_err3",      32'(err3), 32'd0);

        reset = 1'b0; if4.in_valid = 1'b0; if3.in_valid = 1'b0;
        obs4.delete(); obs3.delete();
        idle(1);

        // 8-beat packet to channel 2 at full rate.
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, 16'(i), 2'd2, i == 8);
            if (i == 1) begin
                check("stream_first_valid", 32'(if4.out_valid), 32'h4);
                check("stream_first_data",  32'(if4.out_data[47:32]), 32'h1);
            end
            check($sformatf("stream_busy%0d", i), 32'(busy4), (i == 8) ? 32'd0 : 32'd1);
            exp_q.push_back(mk(2, i == 8, 16'(i)));
        end
        idle(3);
        check_obs("stream", 1'b0);
        check("stream_drained", 32'(if4.out_valid), 32'd0);

        // Backpressure on channel 1: third beat must stall.
        if4.out_ready = 4'b1101;
        send(1'b0, 16'h0011, 2'd1, 1'b0);
        send(1'b0, 16'h0012, 2'd1, 1'b0);
        if4.in_data = 16'h0013; if4.in_sel = 2'd1; if4.in_last = 1'b0; if4.in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 32'(if4.in_ready), 32'd0);
        check("bp_out_valid", 32'(if4.out_valid), 32'h2);
        check("bp_out_head", 32'(if4.out_data[31:16]), 32'h0011);
        check("bp_no_pops", 32'(obs4.size()), 32'd0);
        @(posedge clk); #1;
        if4.out_ready = 4'hF;
        send(1'b0, 16'h0013, 2'd1, 1'b0);
        send(1'b0, 16'h0014, 2'd1, 1'b1);
        idle(3);
        for (int i = 1; i <= 4; i++) exp_q.push_back(mk(1, i == 4, 16'h0010 + 16'(i)));
        check_obs("bp", 1'b0);

        // Sel lock: in_sel wanders mid-packet, packet stays on channel 0.
        send(1'b0, 16'h0021, 2'd0, 1'b0);
        send(1'b0, 16'h0022, 2'd3, 1'b0);
        send(1'b0, 16'h0023, 2'd3, 1'b0);
        send(1'b0, 16'h0024, 2'd1, 1'b1);
        send(1'b0, 16'h0031, 2'd3, 1'b0);
        send(1'b0, 16'h0032, 2'd0, 1'b1);
        idle(3);
        for (int i = 1; i <= 4; i++) exp_q.push_back(mk(0, i == 4, 16'h0020 + 16'(i)));
        exp_q.push_back(mk(3, 1'b0, 16'h0031));
        exp_q.push_back(mk(3, 1'b1, 16'h0032));
        check_obs("lock", 1'b0);
        check("lock_err4", 32'(err4), 32'd0);

        // Bad destination on the 3-channel instance.
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 16'h0040 + 16'(i), 2'd3, i == 4);
            check($sformatf("drop_busy%0d", i), 32'(busy3), 32'd0);
        end
        idle(2);
        check("drop_err", 32'(err3), 32'd1);
        check("drop_out_valid", 32'(if3.out_valid), 32'd0);
        check_obs("drop", 1'b1);
        send(1'b1, 16'h0051, 2'd0, 1'b0);
        send(1'b1, 16'h0052, 2'd0, 1'b1);
        idle(3);
        exp_q.push_back(mk(0, 1'b0, 16'h0051));
        exp_q.push_back(mk(0, 1'b1, 16'h0052));
        check_obs("after_drop", 1'b1);
        check("err_sticky", 32'(err3), 32'd1);

        // Reset in the middle of a packet with channel 1 full.
        if4.out_ready = 4'b1101;
        send(1'b0, 16'h0071, 2'd1, 1'b0);
        send(1'b0, 16'h0072, 2'd1, 1'b0);
        check("mid_full", 32'(if4.out_valid), 32'h2);
        if4.in_data = 16'h0073; if4.in_sel = 2'd1; if4.in_valid = 1'b1;
        reset = 1'b1;
        idle(1);
        check("mid_out_valid", 32'(if4.out_valid), 32'd0);
        check("mid_busy", 32'(busy4), 32'd0);
        check("mid_out_data", 32'(if4.out_data[31:16]), 32'd0);
        check("mid_err3_clr", 32'(err3), 32'd0);
        reset = 1'b0; if4.in_valid = 1'b0; if4.out_ready = 4'hF;
        send(1'b0, 16'h0081, 2'd2, 1'b0);
        send(1'b0, 16'h0082, 2'd2, 1'b1);
        idle(3);
        exp_q.push_back(mk(2, 1'b0, 16'h0081));
        exp_q.push_back(mk(2, 1'b1, 16'h0082));
        check_obs("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
